// File: rtl/exception_controller.sv
// Exception and interrupt controller: synchronises and latches the external
// IRQ lines, prioritises synchronous exceptions against interrupts, captures
// the cause/EPC/BD values for COP0 and sequences the pipeline flush and the
// fetch redirect to the handler entry point.
module exception_controller #(
    parameter logic [31:0] HANDLER_ADDR = 32'h80000180,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic        iCLK,
    input  logic        iCLR,
    input  logic [6:0]  iIRQ,
    input  logic [6:0]  iIrqClear,
    input  logic [7:0]  iInterruptMask,
    input  logic        iExcLevel,
    input  logic        iAddrErrLoad,
    input  logic        iAddrErrStore,
    input  logic        iIllegalInstr,
    input  logic        iOverflow,
    input  logic        iSyscall,
    input  logic        iBreak,
    input  logic [31:0] iPC,
    input  logic        iInBranchDelay,
    input  logic        iStall,
    input  logic        iEret,
    output logic [7:0]  oPendingInterrupt,
    output logic        oExcOccurred,
    output logic [4:0]  oExcCode,
    output logic        oBranchDelay,
    output logic [31:0] oEPC,
    output logic        oFlush,
    output logic        oRedirect,
    output logic [31:0] oRedirectPC,
    output logic        oBusy
);

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_ADEL = 5'd4;
    localparam logic [4:0] CODE_ADES = 5'd5;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_BP   = 5'd9;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_OV   = 5'd12;

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        REDIRECT,
        HANDLER
    } state_t;

    state_t                         state_q, state_d;
    logic [SYNC_STAGES-1:0][6:0]    sync_q, sync_d;
    logic [6:0]                     irq_prev_q, irq_prev_d;
    logic [6:0]                     pending_q, pending_d;
    logic [4:0]                     exc_code_q, exc_code_d;
    logic                           bd_q, bd_d;
    logic [31:0]                    epc_q, epc_d;

    logic [6:0]                     irq_rise;
    logic                           sync_req;
    logic                           int_req;
    logic [4:0]                     trap_code;

    // IRQ synchroniser chain, edge detector and sticky pending latch
    always_comb begin
        sync_d[0] = iIRQ;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        irq_prev_d = sync_q[SYNC_STAGES-1];
        irq_rise   = sync_q[SYNC_STAGES-1] & ~irq_prev_q;
        // set is OR-ed in after the clear so a same-cycle set wins
        pending_d  = (pending_q & ~iIrqClear) | irq_rise;
    end

    // Trap request detection and fixed-priority cause encoding
    always_comb begin
        sync_req = iAddrErrLoad | iAddrErrStore | iIllegalInstr |
                   iOverflow | iSyscall | iBreak;
        int_req  = (|iInterruptMask) & ~iExcLevel;
        if (iAddrErrLoad)       trap_code = CODE_ADEL;
        else if (iAddrErrStore) trap_code = CODE_ADES;
        else if (iIllegalInstr) trap_code = CODE_RI;
        else if (iOverflow)     trap_code = CODE_OV;
        else if (iSyscall)      trap_code = CODE_SYS;
        else if (iBreak)        trap_code = CODE_BP;
        else                    trap_code = CODE_INT;
    end

    // Trap sequencing FSM: next state, cause capture and Moore outputs
    always_comb begin
        state_d      = state_q;
        exc_code_d   = exc_code_q;
        bd_d         = bd_q;
        epc_d        = epc_q;
        oExcOccurred = 1'b0;
        oFlush       = 1'b0;
        oRedirect    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sync_req || int_req) begin
                    exc_code_d = trap_code;
                    bd_d       = iInBranchDelay;
                    epc_d      = iInBranchDelay ? (iPC - 32'd4) : iPC;
                    state_d    = COMMIT;
                end
            end
            COMMIT: begin
                oExcOccurred = 1'b1;
                oFlush       = 1'b1;
                oRedirect    = 1'b1;
                state_d      = REDIRECT;
            end
            REDIRECT: begin
                oFlush    = 1'b1;
                oRedirect = 1'b1;
                if (!iStall) state_d = HANDLER;
            end
            HANDLER: begin
                if (iEret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output wiring that does not depend on the FSM decision
    always_comb begin
        oPendingInterrupt = {1'b0, pending_q};
        oExcCode          = exc_code_q;
        oBranchDelay      = bd_q;
        oEPC              = epc_q;
        oRedirectPC       = HANDLER_ADDR;
        oBusy             = (state_q != IDLE);
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge iCLK) begin
        if (iCLR) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            irq_prev_q <= '0;
            pending_q  <= '0;
            exc_code_q <= '0;
            bd_q       <= 1'b0;
            epc_q      <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
            exc_code_q <= exc_code_d;
            bd_q       <= bd_d;
            epc_q      <= epc_d;
        end
    end

endmodule

// File: tb/tb_exception_controller.sv
// Directed bench for exception_controller: expected cause/BD/EPC records are
// queued when a trap is provoked and popped when oExcOccurred pulses.
module tb_exception_controller;

    logic        iCLK = 1'b0;
    logic        iCLR;
    logic [6:0]  iIRQ;
    logic [6:0]  iIrqClear;
    logic [7:0]  iInterruptMask;
    logic        iExcLevel;
    logic        iAddrErrLoad, iAddrErrStore, iIllegalInstr;
    logic        iOverflow, iSyscall, iBreak;
    logic [31:0] iPC;
    logic        iInBranchDelay;
    logic        iStall;
    logic        iEret;
    logic [7:0]  oPendingInterrupt;
    logic        oExcOccurred;
    logic [4:0]  oExcCode;
    logic        oBranchDelay;
    logic [31:0] oEPC;
    logic        oFlush;
    logic        oRedirect;
    logic [31:0] oRedirectPC;
    logic        oBusy;

    typedef struct {
        logic [4:0]  code;
        logic        bd;
        logic [31:0] epc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    exception_controller #(
        .HANDLER_ADDR (32'h80000180),
        .SYNC_STAGES  (2)
    ) dut (
        .iCLK              (iCLK),
        .iCLR              (iCLR),
        .iIRQ              (iIRQ),
        .iIrqClear         (iIrqClear),
        .iInterruptMask    (iInterruptMask),
        .iExcLevel         (iExcLevel),
        .iAddrErrLoad      (iAddrErrLoad),
        .iAddrErrStore     (iAddrErrStore),
        .iIllegalInstr     (iIllegalInstr),
        .iOverflow         (iOverflow),
        .iSyscall          (iSyscall),
        .iBreak            (iBreak),
        .iPC               (iPC),
        .iInBranchDelay    (iInBranchDelay),
        .iStall            (iStall),
        .iEret             (iEret),
        .oPendingInterrupt (oPendingInterrupt),
        .oExcOccurred      (oExcOccurred),
        .oExcCode          (oExcCode),
        .oBranchDelay      (oBranchDelay),
        .oEPC              (oEPC),
        .oFlush            (oFlush),
        .oRedirect         (oRedirect),
        .oRedirectPC       (oRedirectPC),
        .oBusy             (oBusy)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge iCLK);
    endtask

    task automatic push_exp(input logic [4:0] code, input logic bd, input logic [31:0] epc);
        exp_t e;
        e.code = code;
        e.bd   = bd;
        e.epc  = epc;
        sb.push_back(e);
    endtask

    // Advance until the FSM sits in HANDLER, then eret back to IDLE
    task automatic run_to_idle(input string tag);
        bit reached = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (oBusy && !oRedirect) begin
                reached = 1'b1;
                break;
            end
            step();
        end
        check({tag, "_reach_handler"}, 32'(reached), 32'd1);
        iEret = 1'b1;
        step();
        iEret = 1'b0;
        check({tag, "_idle_after_eret"}, 32'(oBusy), 32'd0);
    endtask

    // Scoreboard: every commit pulse must match the oldest queued expectation
    always @(negedge iCLK) begin
        if (oExcOccurred) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL sb_unexpected_commit: observed code %0d expected no commit", oExcCode);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_code", 32'(oExcCode), 32'(e.code));
                check("sb_bd", 32'(oBranchDelay), 32'(e.bd));
                check("sb_epc", oEPC, e.epc);
            end
        end
    end

    initial begin
        int redir_cnt;
        int occ_cnt;

        iCLR = 1'b1; iIRQ = '0; iIrqClear = '0; iInterruptMask = '0; iExcLevel = 1'b0;
        iAddrErrLoad = 1'b0; iAddrErrStore = 1'b0; iIllegalInstr = 1'b0;
        iOverflow = 1'b0; iSyscall = 1'b0; iBreak = 1'b0;
        iPC = '0; iInBranchDelay = 1'b0; iStall = 1'b0; iEret = 1'b0;
        step(); step();
        iCLR = 1'b0;

        // Reset state
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_occ", 32'(oExcOccurred), 32'd0);
        check("rst_flush", 32'(oFlush), 32'd0);
        check("rst_redirect", 32'(oRedirect), 32'd0);
        check("rst_code", 32'(oExcCode), 32'd0);
        check("rst_bd", 32'(oBranchDelay), 32'd0);
        check("rst_epc", oEPC, 32'd0);
        check("rst_pending", 32'(oPendingInterrupt), 32'd0);

        // Overflow trap, one-cycle latency
        iOverflow = 1'b1; iPC = 32'h00400020; iInBranchDelay = 1'b0;
        push_exp(5'd12, 1'b0, 32'h00400020);
        step();
        iOverflow = 1'b0;
        check("ov_occ", 32'(oExcOccurred), 32'd1);
        check("ov_redirect", 32'(oRedirect), 32'd1);
        check("ov_flush", 32'(oFlush), 32'd1);
        check("ov_redirect_pc", oRedirectPC, 32'h80000180);
        step();
        check("ov_redirect_exit", 32'(oRedirect), 32'd1);
        check("ov_occ_single", 32'(oExcOccurred), 32'd0);
        step();
        check("ov_handler_redirect", 32'(oRedirect), 32'd0);
        check("ov_handler_busy", 32'(oBusy), 32'd1);
        check("ov_code_held", 32'(oExcCode), 32'd12);
        run_to_idle("ov");

        // Simultaneous AdEL + syscall in a delay slot
        iSyscall = 1'b1; iAddrErrLoad = 1'b1; iPC = 32'h00400104; iInBranchDelay = 1'b1;
        push_exp(5'd4, 1'b1, 32'h00400100);
        step();
        iSyscall = 1'b0; iAddrErrLoad = 1'b0; iInBranchDelay = 1'b0;
        run_to_idle("adel");

        // Priority RI over Ov/Sys/Bp, EPC wrap at PC=0, stall 3 cycles, eret ignored while redirecting
        iIllegalInstr = 1'b1; iOverflow = 1'b1; iBreak = 1'b1;
        iPC = 32'h00000000; iInBranchDelay = 1'b1; iStall = 1'b1;
        push_exp(5'd10, 1'b1, 32'hFFFFFFFC);
        redir_cnt = 0;
        occ_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (oRedirect) redir_cnt++;
            if (oExcOccurred) occ_cnt++;
            if (i == 1) begin
                iIllegalInstr = 1'b0; iOverflow = 1'b0; iBreak = 1'b0;
                iInBranchDelay = 1'b0; iEret = 1'b1;
            end
            if (i == 5) begin
                iStall = 1'b0;
                iEret = 1'b0;
            end
        end
        check("stall_redirect_cycles", 32'(redir_cnt), 32'd5);
        check("stall_occ_cycles", 32'(occ_cnt), 32'd1);
        check("stall_in_handler", 32'(oBusy), 32'd1);
        run_to_idle("stall");

        // IRQ[2] rise: synchroniser latency, then interrupt trap
        iIRQ = 7'b0000100;
        step(); step();
        check("irq_not_yet", 32'(oPendingInterrupt), 32'h00);
        step();
        check("irq_pending", 32'(oPendingInterrupt), 32'h04);
        iInterruptMask = 8'h04; iPC = 32'h00400200;
        push_exp(5'd0, 1'b0, 32'h00400200);
        step();
        iInterruptMask = 8'h00;
        check("irq_occ", 32'(oExcOccurred), 32'd1);
        for (int i = 0; i < 20 && !(oBusy && !oRedirect); i++) step();

        // Requests ignored in HANDLER
        iOverflow = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("handler_no_nest", 32'(oExcOccurred), 32'd0);
            check("handler_busy", 32'(oBusy), 32'd1);
        end
        iOverflow = 1'b0; iEret = 1'b1;
        step();
        iEret = 1'b0;
        check("eret_idle", 32'(oBusy), 32'd0);
        step();
        check("eret_stays_idle", 32'(oBusy), 32'd0);

        // Software clear, and set beating a same-cycle clear
        iIrqClear = 7'b0000100;
        step();
        iIrqClear = '0;
        check("irq_cleared", 32'(oPendingInterrupt), 32'h00);
        iIRQ = 7'b0001100;
        step(); step();
        iIrqClear = 7'b0001000;
        step();
        iIrqClear = '0;
        check("set_beats_clear", 32'(oPendingInterrupt), 32'h08);
        iIrqClear = 7'b0001000;
        step();
        iIrqClear = '0;
        check("irq3_cleared", 32'(oPendingInterrupt), 32'h00);
        iIRQ = '0;
        step();

        // Reset mid-REDIRECT with every pending bit set
        iIRQ = 7'h7F;
        step(); step(); step();
        check("all_pending", 32'(oPendingInterrupt), 32'h7F);
        iBreak = 1'b1; iStall = 1'b1; iPC = 32'h00400300;
        push_exp(5'd9, 1'b0, 32'h00400300);
        step();
        iBreak = 1'b0;
        step();
        check("mid_redirect", 32'(oRedirect), 32'd1);
        check("pending_in_redirect", 32'(oPendingInterrupt), 32'h7F);
        iCLR = 1'b1;
        step();
        iCLR = 1'b0; iStall = 1'b0; iIRQ = '0;
        check("clr_busy", 32'(oBusy), 32'd0);
        check("clr_redirect", 32'(oRedirect), 32'd0);
        check("clr_flush", 32'(oFlush), 32'd0);
        check("clr_occ", 32'(oExcOccurred), 32'd0);
        check("clr_code", 32'(oExcCode), 32'd0);
        check("clr_epc", oEPC, 32'd0);
        check("clr_pending", 32'(oPendingInterrupt), 32'h00);
        step();
        check("clr_stays_idle", 32'(oBusy), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exception_controller.md
EXCEPTION_CONTROLLER -- requirements
Module: exception_controller

Interface
REQ-001 Parameter HANDLER_ADDR, default 32'h80000180, is the exception handler entry PC.
REQ-002 Parameter SYNC_STAGES, default 2, is the synchronizer depth for the raw IRQ lines (minimum 2).
REQ-003 iCLK  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 iCLR  in  1  reset, synchronous and active-high.
REQ-005 iIRQ  in  7  raw asynchronous external interrupt lines.
REQ-006 iIrqClear  in  7  per-bit software clear of latched pending IRQs.
REQ-007 iInterruptMask  in  8  enabled and masked interrupts from the COP0 register file.
REQ-008 iExcLevel  in  1  COP0 SR.EL bit.
REQ-009 iAddrErrLoad, iAddrErrStore, iIllegalInstr, iOverflow, iSyscall, iBreak  in  1 each  synchronous exception requests for the instruction at iPC.
REQ-010 iPC  in  32  PC of the instruction currently eligible to trap.
REQ-011 iInBranchDelay  in  1  the instruction at iPC sits in a branch delay slot.
REQ-012 iStall  in  1  the fetch stage cannot accept a redirect this cycle.
REQ-013 iEret  in  1  an eret instruction is executing.
REQ-014 oPendingInterrupt  out  8  {1'b0, latched pending[6:0]}, routed to COP0.
REQ-015 oExcOccurred  out  1  one-cycle commit pulse to COP0.
REQ-016 oExcCode  out  5  cause code.
REQ-017 oBranchDelay  out  1  Cause.BD value.
REQ-018 oEPC  out  32  EPC value to COP0.
REQ-019 oFlush  out  1  squash the younger pipeline instructions.
REQ-020 oRedirect  out  1  the fetch stage loads oRedirectPC.
REQ-021 oRedirectPC  out  32  equals HANDLER_ADDR.
REQ-022 oBusy  out  1  high in every state except IDLE.

Function
REQ-023 Each iIRQ bit SHALL pass through a SYNC_STAGES flop synchronizer followed by a rising-edge detector.
REQ-024 A detected rising edge SHALL set pending[i], which stays set until an iIrqClear[i] pulse.
REQ-025 A set and a clear of the same bit in the same cycle SHALL leave the bit set.
REQ-026 The FSM SHALL have exactly four states: IDLE, COMMIT, REDIRECT, HANDLER.
REQ-027 In IDLE, a trap is requested by any synchronous request, or by (|iInterruptMask and !iExcLevel).
REQ-028 Trap priority, with its code: AdEL 4 > AdES 5 > RI 10 > Ov 12 > Sys 8 > Bp 9 > Int 0.
REQ-029 When multiple requests are active, only the highest-priority code SHALL be taken.
REQ-030 On the IDLE cycle with a trap request, the block SHALL register oExcCode, oBranchDelay=iInBranchDelay and oEPC, then move to COMMIT.
REQ-031 oEPC SHALL be iPC-4 when iInBranchDelay=1, else iPC, computed modulo 2^32 (iPC=0 with BD=1 gives 32'hFFFFFFFC).
REQ-032 COMMIT lasts exactly one cycle: oExcOccurred=1, oFlush=1, oRedirect=1, then move to REDIRECT.
REQ-033 REDIRECT holds oRedirect=1 and oFlush=1 while iStall=1.
REQ-034 REDIRECT exits to HANDLER on the first cycle with iStall=0; oRedirect stays high during that exit cycle.
REQ-035 In HANDLER, all exception and interrupt requests SHALL be ignored (no nesting).
REQ-036 In HANDLER, iEret=1 SHALL return the FSM to IDLE on the next cycle.
REQ-037 iEret SHALL be ignored in IDLE, COMMIT and REDIRECT.
REQ-038 oExcCode, oBranchDelay and oEPC SHALL hold their captured values until the next trap capture.
REQ-039 Latency from a request in IDLE to the oExcOccurred pulse SHALL be exactly 1 cycle.
REQ-040 Latency from a request in IDLE to the first oRedirect SHALL be exactly 1 cycle.
REQ-041 Pending IRQs SHALL keep latching in every state.

Reset
REQ-042 iCLR=1 at a clock edge SHALL force IDLE, from any state including mid-REDIRECT.
REQ-043 iCLR=1 SHALL clear synchronizers, edge detectors and pending to 0.
REQ-044 After reset, oExcOccurred, oFlush, oRedirect and oBusy SHALL be 0.
REQ-045 After reset, oExcCode, oBranchDelay, oEPC and oPendingInterrupt SHALL be 0.
REQ-046 iCLR SHALL take precedence over every other input.

Verification
REQ-047 iOverflow=1, iPC=32'h00400020, BD=0 in IDLE -> next cycle oExcOccurred=1, oExcCode=12, oEPC=32'h00400020, oRedirectPC=32'h80000180.
REQ-048 iSyscall=1 and iAddrErrLoad=1 together, iPC=32'h00400104, BD=1 -> oExcCode=4, oBranchDelay=1, oEPC=32'h00400100.
REQ-049 iIRQ[2] rises, iInterruptMask=8'h04, iExcLevel=0 -> pending visible as oPendingInterrupt=8'h04 after SYNC_STAGES+1 cycles; trap with oExcCode=0 one cycle later.
REQ-050 iStall=1 for 3 cycles after COMMIT -> oRedirect high 5 cycles total; oExcOccurred high exactly 1 cycle.
REQ-051 In HANDLER, iOverflow=1 -> no pulse; then iEret=1 -> IDLE next cycle, oBusy=0.
REQ-052 iCLR=1 during REDIRECT with pending=7'h7F -> next cycle IDLE, all outputs 0.
